core_msg_rx: RTL and testbench
==============================

Name: core_msg_rx

Overview:
- Per-core receive stage, one instance per core, directly downstream of the GPU scheduler's message bus.
- Decodes the 16-bit broadcast message stream using the four loading strobes (core_mask, r0_mask, r0, instr).
- Assembles R0 initial data into a 128-bit register and buffers the task's instruction stream in a FIFO for the core's fetch stage.
- Returns per-core core_reading (accept) and core_ready (idle) to the scheduler.

Parameters:
- CORE_ID, 0: bit index of this core in the core and R0 masks.
- CORE_NUM, 16: mask width.
- BUS_W, 16: message bus width.
- INSTR_SIZE, 16: instruction width.
- R0_DEPTH, 8: R0 words per task.
- R0_DATA_SIZE, 128: R0 register width; equals R0_DEPTH*BUS_W.
- IBUF_DEPTH, 32: instruction FIFO entries; power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- mess_to_core  in  BUS_W  message word.
- core_mask_loading  in  1  word is the core mask.
- r0_mask_loading  in  1  word is the R0 mask.
- r0_loading  in  1  word is R0 data.
- instr_loading  in  1  word is an instruction.
- core_reading  out  1  core can accept a word next cycle.
- core_ready  out  1  core idle / available.
- r0_data  out  R0_DATA_SIZE  assembled R0.
- r0_valid  out  1  one-cycle pulse: r0_data complete.
- fetch_valid  out  1  FIFO non-empty.
- fetch_instr  out  INSTR_SIZE  FIFO head, first-word-fall-through.
- fetch_pop  in  1  consume head; ignored when empty.
- exec_idle  in  1  core pipeline drained.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (one cycle, any state): state=IDLE, FIFO empty, r0_idx=0, r0_sel=0, r0_data=0, r0_valid=0, proto_err=0. Outputs then read core_ready=1, core_reading=1, fetch_valid=0.
- Strobes are one-hot per cycle. Two or more strobes high in one cycle sets proto_err and the word is ignored.
- core_mask_loading:
  - IDLE and mess[CORE_ID]=1: go to LOAD; core_ready<=0 (registered, low the cycle after the mask word).
  - IDLE and bit clear: stay IDLE.
  - Any other state with bit set: proto_err<=1, state unchanged.
- r0_mask_loading: r0_sel<=mess[CORE_ID], r0_idx<=0. Accepted in every state.
- r0_loading: r0_data[BUS_W*r0_idx +: BUS_W]<=mess; r0_idx increments and wraps mod R0_DEPTH. The word is written even when r0_sel=0 (r0_data is don't-care then). When r0_idx==R0_DEPTH-1 and r0_sel=1, r0_valid pulses 1 the next cycle. Extra words beyond R0_DEPTH overwrite from slot 0; this is not an error.
- instr_loading, by state:
  - IDLE, RUN, FIN: word dropped.
  - LOAD: word pushed. If the word equals RX_END_INSTR, it is pushed and state goes to RUN.
- FIFO:
  - Push and pop in the same cycle are both allowed; count unchanged.
  - Push while count==IBUF_DEPTH and no pop: word dropped, proto_err<=1.
  - fetch_instr is undefined when empty.
- core_reading (combinational from registered state and count):
  - LOAD: 1 iff count <= IBUF_DEPTH-2. This gives one skid slot, because the scheduler registers a word one cycle after sampling core_reading. Max occupancy is IBUF_DEPTH with no loss.
  - IDLE, RUN, FIN: 1.
- State transitions:
  - RUN -> FIN when fetch_pop=1 and fetch_instr==RX_END_INSTR.
  - FIN -> IDLE when exec_idle=1; core_ready<=1 on the same edge. The FIFO is empty at that point by construction.
  - An END pop while in LOAD is impossible, because END causes the LOAD->RUN transition on push.
- Latencies:
  - mask word to core_ready low: 1 cycle.
  - instr word to fetch_valid: 1 cycle.
  - 8th R0 word to r0_valid: 1 cycle.

Decomposition:
- Shared package rx_def.v:
  - RX_END_INSTR = 16'hFFFF.
  - State encodings: RX_IDLE=2'd0, RX_LOAD=2'd1, RX_RUN=2'd2, RX_FIN=2'd3.
- Sub-module rx_instr_fifo:
  - Synchronous FWFT FIFO, parameters WIDTH and DEPTH.
  - Ports: push, din, pop, dout, count, empty, full.
  - Drop-on-full behaviour exposed via an overflow output.
- Top module: FSM, R0 assembler, core_reading logic, error logic.

Test Plan (CORE_ID=3):
- Reset held 2 cycles, released -> core_ready=1, core_reading=1, fetch_valid=0, r0_valid=0, proto_err=0, r0_data=0.
- core_mask 16'h0008, r0_mask 16'h0008, R0 words 16'h1000..16'h1007 -> core_ready=0 from the cycle after the mask word. r0_valid pulses the cycle after 16'h1007. r0_data=128'h1007_1006_1005_1004_1003_1002_1001_1000.
- core_mask 16'h0004 then instr 16'hA001 -> stays IDLE, core_ready=1, fetch_valid=0 throughout.
- Selected, fetch_pop=0, scheduler model streams 40 instr words gated by core_reading -> core_reading=0 once count>=31, count peaks at 32, proto_err=0. Popping returns the first 32 words in order; the remaining 8 follow after core_reading reasserts.
- Stream 16'h0101, 16'h0202, 16'hFFFF, 16'h0303 -> FIFO holds 3 words and 16'h0303 is dropped. Popping 16'hFFFF moves to FIN. exec_idle=0 for 5 cycles keeps core_ready=0; exec_idle=1 gives core_ready=1 next cycle.
- In LOAD: core_mask 16'h0008 again -> proto_err=1 and sticky, state still LOAD. Then reset mid-LOAD for 1 cycle -> all outputs at reset values the following cycle.

Source files
------------

// File: rtl/core_msg_rx_pkg.sv
// Shared definitions for the per-core message receive stage.
//   RX_END_INSTR : instruction word that terminates a task's instruction stream.
//   rx_state_e   : receive FSM state encoding.
package core_msg_rx_pkg;

    localparam logic [15:0] RX_END_INSTR = 16'hFFFF;

    typedef enum logic [1:0] {
        RxIdle = 2'd0,
        RxLoad = 2'd1,
        RxRun  = 2'd2,
        RxFin  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/core_msg_rx_instr_fifo.sv
// Synchronous first-word-fall-through instruction FIFO.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (empties the FIFO)
//   push, din   : write request and data; dropped when full and no pop
//   pop         : consume head; ignored when empty
//   dout        : current head (undefined when empty)
//   count       : occupancy, 0..DEPTH
//   empty, full : occupancy flags
//   overflow    : combinational, high when this cycle's push is dropped
module core_msg_rx_instr_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned CntW  = AddrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CntW'(DEPTH));
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & ~do_push;
    assign dout     = mem[rd_ptr_q];
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receive stage downstream of the scheduler message bus. Decodes the four
// loading strobes, assembles R0 initial data and buffers the task's instruction stream.
// Ports:
//   clk, reset             : clock, synchronous active-high reset
//   mess_to_core           : broadcast message word
//   *_loading              : one-hot strobes qualifying mess_to_core
//   core_reading           : this core can accept a word next cycle
//   core_ready             : this core is idle
//   r0_data, r0_valid      : assembled R0 and its one-cycle completion pulse
//   fetch_valid/instr/pop  : FWFT instruction interface to the fetch stage
//   exec_idle              : core pipeline drained
//   proto_err              : sticky protocol-violation flag
module core_msg_rx
    import core_msg_rx_pkg::*;
#(
    parameter int unsigned CORE_ID      = 0,
    parameter int unsigned CORE_NUM     = 16,
    parameter int unsigned BUS_W        = 16,
    parameter int unsigned INSTR_SIZE   = 16,
    parameter int unsigned R0_DEPTH     = 8,
    parameter int unsigned R0_DATA_SIZE = 128,
    parameter int unsigned IBUF_DEPTH   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUS_W-1:0]        mess_to_core,
    input  logic                    core_mask_loading,
    input  logic                    r0_mask_loading,
    input  logic                    r0_loading,
    input  logic                    instr_loading,
    output logic                    core_reading,
    output logic                    core_ready,
    output logic [R0_DATA_SIZE-1:0] r0_data,
    output logic                    r0_valid,
    output logic                    fetch_valid,
    output logic [INSTR_SIZE-1:0]   fetch_instr,
    input  logic                    fetch_pop,
    input  logic                    exec_idle,
    output logic                    proto_err
);

    localparam int unsigned R0IdxW = (R0_DEPTH > 1) ? $clog2(R0_DEPTH) : 1;
    localparam int unsigned CntW   = $clog2(IBUF_DEPTH) + 1;

    rx_state_e               state_q, state_d;
    logic [R0IdxW-1:0]       r0_idx_q, r0_idx_d;
    logic                    r0_sel_q, r0_sel_d;
    logic [R0_DATA_SIZE-1:0] r0_data_q, r0_data_d;
    logic                    r0_valid_q, r0_valid_d;
    logic                    proto_err_q, proto_err_d;

    logic [3:0]              strobes;
    logic                    multi_strobe;
    logic                    cm_ok, r0m_ok, r0_ok, ins_ok;
    logic                    core_hit;

    logic                    fifo_push;
    logic                    fifo_empty, fifo_full, fifo_overflow;
    logic [CntW-1:0]         fifo_count;
    logic                    end_popped;
    logic                    unused_fifo_full;

    assign strobes      = {instr_loading, r0_loading, r0_mask_loading, core_mask_loading};
    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_strobe = (strobes & (strobes - 4'd1)) != 4'd0;
    assign cm_ok        = core_mask_loading & ~multi_strobe;
    assign r0m_ok       = r0_mask_loading & ~multi_strobe;
    assign r0_ok        = r0_loading & ~multi_strobe;
    assign ins_ok       = instr_loading & ~multi_strobe;
    assign core_hit     = mess_to_core[CORE_ID];

    assign fifo_push    = ins_ok & (state_q == RxLoad);
    assign end_popped   = fetch_pop & ~fifo_empty & (fetch_instr == RX_END_INSTR);
    assign unused_fifo_full = fifo_full;

    core_msg_rx_instr_fifo #(
        .WIDTH (INSTR_SIZE),
        .DEPTH (IBUF_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .din      (mess_to_core[INSTR_SIZE-1:0]),
        .pop      (fetch_pop),
        .dout     (fetch_instr),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .overflow (fifo_overflow)
    );

    always_comb begin
        state_d     = state_q;
        r0_idx_d    = r0_idx_q;
        r0_sel_d    = r0_sel_q;
        r0_data_d   = r0_data_q;
        r0_valid_d  = 1'b0;
        proto_err_d = proto_err_q | multi_strobe | fifo_overflow;

        if (cm_ok && core_hit && (state_q != RxIdle)) proto_err_d = 1'b1;

        case (state_q)
            RxIdle: if (cm_ok && core_hit) state_d = RxLoad;
            RxLoad: if (fifo_push && (mess_to_core[INSTR_SIZE-1:0] == RX_END_INSTR)) begin
                state_d = RxRun;
            end
            RxRun:  if (end_popped) state_d = RxFin;
            RxFin:  if (exec_idle) state_d = RxIdle;
            default: state_d = RxIdle;
        endcase

        if (r0m_ok) begin
            r0_sel_d = mess_to_core[CORE_ID];
            r0_idx_d = '0;
        end

        // Words are stored even when deselected; r0_data is simply meaningless then.
        if (r0_ok) begin
            for (int i = 0; i < int'(R0_DEPTH); i++) begin
                if (r0_idx_q == R0IdxW'(i)) r0_data_d[i*BUS_W +: BUS_W] = mess_to_core;
            end
            if (r0_idx_q == R0IdxW'(R0_DEPTH - 1)) begin
                r0_idx_d   = '0;
                r0_valid_d = r0_sel_q;
            end else begin
                r0_idx_d   = r0_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RxIdle;
            r0_idx_q    <= '0;
            r0_sel_q    <= 1'b0;
            r0_data_q   <= '0;
            r0_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r0_idx_q    <= r0_idx_d;
            r0_sel_q    <= r0_sel_d;
            r0_data_q   <= r0_data_d;
            r0_valid_q  <= r0_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    // core_ready tracks the registered state, so it drops the cycle after the mask word.
    assign core_ready   = (state_q == RxIdle);
    // Leave one skid slot: the scheduler's word arrives a cycle after it samples this.
    assign core_reading = (state_q == RxLoad) ? (fifo_count <= CntW'(IBUF_DEPTH - 2)) : 1'b1;
    assign fetch_valid  = ~fifo_empty;
    assign r0_data      = r0_data_q;
    assign r0_valid     = r0_valid_q;
    assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_core_msg_rx.sv
module tb_core_msg_rx;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  mess_to_core;
    logic         core_mask_loading, r0_mask_loading, r0_loading, instr_loading;
    logic         core_reading, core_ready;
    logic [127:0] r0_data;
    logic         r0_valid, fetch_valid;
    logic [15:0]  fetch_instr;
    logic         fetch_pop, exec_idle, proto_err;

    int tests = 0;
    int fails = 0;

    logic [15:0]  fq[$];
    logic [127:0] r0q[$];

    always #5 clk = ~clk;

    core_msg_rx #(
        .CORE_ID (3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mess_to_core      (mess_to_core),
        .core_mask_loading (core_mask_loading),
        .r0_mask_loading   (r0_mask_loading),
        .r0_loading        (r0_loading),
        .instr_loading     (instr_loading),
        .core_reading      (core_reading),
        .core_ready        (core_ready),
        .r0_data           (r0_data),
        .r0_valid          (r0_valid),
        .fetch_valid       (fetch_valid),
        .fetch_instr       (fetch_instr),
        .fetch_pop         (fetch_pop),
        .exec_idle         (exec_idle),
        .proto_err         (proto_err)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs read there are post-edge values.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_mask_loading = 1'b0;
        r0_mask_loading   = 1'b0;
        r0_loading        = 1'b0;
        instr_loading     = 1'b0;
        fetch_pop         = 1'b0;
        mess_to_core      = 16'h0000;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_ready"},   core_ready,   1'b1);
        check({tag, "_core_reading"}, core_reading, 1'b1);
        check({tag, "_fetch_valid"},  fetch_valid,  1'b0);
        check({tag, "_r0_valid"},     r0_valid,     1'b0);
        check({tag, "_proto_err"},    proto_err,    1'b0);
        check({tag, "_r0_data"},      r0_data,      128'h0);
    endtask

    // Scoreboard monitor: compares every fetched instruction and every R0 completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (fetch_pop && fetch_valid) begin
                if (fq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL fetch_unexpected: got %h expected none", fetch_instr);
                end else begin
                    check("fetch_instr", {112'h0, fetch_instr}, {112'h0, fq.pop_front()});
                end
            end
            if (r0_valid) begin
                if (r0q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL r0_unexpected: got %h expected none", r0_data);
                end else begin
                    check("r0_data", r0_data, r0q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   sent;
        int   mcnt;
        int   maxcnt;
        logic grant;
        logic send;
        logic popping;

        clear_inputs();
        exec_idle = 1'b0;
        reset     = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Mask word without our bit, then an instruction: must stay idle.
        step(); core_mask_loading = 1'b1; mess_to_core = 16'h0004;
        step(); clear_inputs();
        check("unsel_ready", core_ready, 1'b1);
        instr_loading = 1'b1; mess_to_core = 16'hA001;
        step(); clear_inputs();
        check("unsel_ready2", core_ready, 1'b1);
        check("unsel_fetch_valid", fetch_valid, 1'b0);

        // Select, then load R0.
        step(); core_mask_loading = 1'b1; mess_to_core = 16'h0008;
        step(); clear_inputs();
        check("sel_ready_low", core_ready, 1'b0);
        r0_mask_loading = 1'b1; mess_to_core = 16'h0008;
        r0q.push_back(128'h1007_1006_1005_1004_1003_1002_1001_1000);
        for (int i = 0; i < 8; i++) begin
            step(); clear_inputs();
            r0_loading = 1'b1; mess_to_core = 16'h1000 + 16'(i);
        end
        step(); clear_inputs();
        check("r0_valid_pulse", r0_valid, 1'b1);
        step();
        check("r0_valid_drop", r0_valid, 1'b0);
        check("r0_data_hold", r0_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);

        // Scheduler model streams 40 words gated by core_reading, no pops.
        sent = 0; mcnt = 0; maxcnt = 0;
        grant = core_reading;
        for (int c = 0; c < 40; c++) begin
            step();
            check("stream_reading", core_reading, (mcnt <= 30));
            send = grant && (sent < 40);
            instr_loading = send;
            mess_to_core  = 16'h2000 + 16'(sent);
            if (send) begin
                fq.push_back(16'h2000 + 16'(sent));
                sent++;
                mcnt++;
            end
            if (mcnt > maxcnt) maxcnt = mcnt;
            grant = core_reading;
        end
        step(); clear_inputs();
        check("stream_sent32", sent, 32);
        check("stream_peak", maxcnt, 32);
        check("stream_reading_low", core_reading, 1'b0);
        check("stream_no_err", proto_err, 1'b0);

        // Drain while the remaining words are streamed in.
        grant = core_reading;
        for (int c = 0; c < 150 && !(sent == 40 && mcnt == 0); c++) begin
            step();
            check("drain_reading", core_reading, (mcnt <= 30));
            send = grant && (sent < 40);
            instr_loading = send;
            mess_to_core  = 16'h2000 + 16'(sent);
            fetch_pop     = 1'b1;
            popping       = (mcnt > 0);
            if (send) begin
                fq.push_back(16'h2000 + 16'(sent));
                sent++;
            end
            mcnt  = mcnt + (send ? 1 : 0) - (popping ? 1 : 0);
            grant = core_reading;
        end
        step(); clear_inputs();
        check("drain_sent40", sent, 40);
        check("drain_empty", fetch_valid, 1'b0);
        check("drain_sb_empty", fq.size(), 0);
        check("drain_no_err", proto_err, 1'b0);

        // END terminates loading; the word after it is dropped.
        instr_loading = 1'b1; mess_to_core = 16'h0101; fq.push_back(16'h0101);
        step(); mess_to_core = 16'h0202; fq.push_back(16'h0202);
        step(); mess_to_core = 16'hFFFF; fq.push_back(16'hFFFF);
        step(); mess_to_core = 16'h0303;
        step(); clear_inputs();
        check("run_fetch_valid", fetch_valid, 1'b1);
        check("run_ready", core_ready, 1'b0);
        fetch_pop = 1'b1;
        step();
        step();
        step(); clear_inputs();
        check("fin_fifo_empty", fetch_valid, 1'b0);
        check("fin_sb_empty", fq.size(), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("fin_ready_low", core_ready, 1'b0);
        end
        exec_idle = 1'b1;
        step(); exec_idle = 1'b0;
        check("fin_to_idle", core_ready, 1'b1);
        check("idle_no_err", proto_err, 1'b0);

        // Second mask hit while loading is an error; state stays in LOAD.
        core_mask_loading = 1'b1; mess_to_core = 16'h0008;
        step();
        step(); clear_inputs();
        check("dup_mask_err", proto_err, 1'b1);
        check("dup_mask_load", core_ready, 1'b0);
        instr_loading = 1'b1; mess_to_core = 16'h1234; fq.push_back(16'h1234);
        step(); clear_inputs();
        check("dup_err_sticky", proto_err, 1'b1);
        check("dup_still_load", fetch_valid, 1'b1);

        // Reset mid-load.
        reset = 1'b1;
        step(); reset = 1'b0;
        fq.delete();
        check_reset_outputs("midreset");

        // Two strobes in one cycle: error, word ignored.
        core_mask_loading = 1'b1; instr_loading = 1'b1; mess_to_core = 16'h0008;
        step(); clear_inputs();
        check("multi_err", proto_err, 1'b1);
        check("multi_ignored", core_ready, 1'b1);
        step();
        check("r0_sb_empty", r0q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
